// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline sequencing controller of the 5-stage
// MIPS core: decoded op encodings, controller FSM states and the layout of
// one in-flight scoreboard slot, plus a helper that builds a slot from the
// decoded ID-stage fields.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int OP_W   = 6;
    localparam int REG_AW = 5;

    // Decoded op encodings produced by the ID stage
    localparam logic [OP_W-1:0] op_nop = 6'h00;
    localparam logic [OP_W-1:0] op_jr  = 6'h08;
    localparam logic [OP_W-1:0] op_lw  = 6'h23;
    localparam logic [OP_W-1:0] op_sw  = 6'h2b;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // One instruction in flight (EX or MEM)
    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic              is_store;
        logic              wr;
        logic [REG_AW-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic slot_t decode_slot(input logic [OP_W-1:0]   op,
                                          input logic              wr,
                                          input logic [REG_AW-1:0] dest);
        slot_t s;
        s.valid    = 1'b1;
        s.is_load  = (op == op_lw);
        s.is_store = (op == op_sw);
        s.wr       = wr;
        s.dest     = dest;
        return s;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the ID-stage observation signals, the data-memory handshake and
// the generated pipeline controls of the sequencing controller.
//   master : pipeline side (drives ID fields and dmem_ack, receives controls)
//   slave  : the controller (pipe_hazard_ctrl)
// Signals:
//   id_valid, id_op, id_rega_read/addr, id_regb_read/addr,
//   id_regc_write/addr, id_jce, dmem_ack           -> controller
//   stall_if, stall_id, bubble_ex, flush_id, freeze,
//   dmem_req, mem_timeout, stall_cycles            <- controller
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic              id_valid;
    logic [OP_W-1:0]   id_op;
    logic              id_rega_read;
    logic              id_regb_read;
    logic [REG_AW-1:0] id_rega_addr;
    logic [REG_AW-1:0] id_regb_addr;
    logic              id_regc_write;
    logic [REG_AW-1:0] id_regc_addr;
    logic              id_jce;
    logic              dmem_ack;

    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_id;
    logic              freeze;
    logic              dmem_req;
    logic              mem_timeout;
    logic [31:0]       stall_cycles;

    modport master (
        output id_valid, id_op, id_rega_read, id_regb_read, id_rega_addr,
               id_regb_addr, id_regc_write, id_regc_addr, id_jce, dmem_ack,
        input  stall_if, stall_id, bubble_ex, flush_id, freeze, dmem_req,
               mem_timeout, stall_cycles
    );

    modport slave (
        input  id_valid, id_op, id_rega_read, id_regb_read, id_rega_addr,
               id_regb_addr, id_regc_write, id_regc_addr, id_jce, dmem_ack,
        output stall_if, stall_id, bubble_ex, flush_id, freeze, dmem_req,
               mem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Two-slot shift register tracking the instructions in EX and MEM, plus the
// load-use compare against the ID-stage source operands.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   advance_i           shift the pipeline (low while frozen)
//   bubble_i            insert an empty slot into EX instead of ID
//   id_*_i              decoded ID-stage fields
//   load_use_o          EX holds a load whose result ID wants now
//   mem_access_o        MEM holds a valid load or store
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
    input  logic              bubble_i,
    input  logic              id_valid_i,
    input  logic [OP_W-1:0]   id_op_i,
    input  logic              id_rega_read_i,
    input  logic [REG_AW-1:0] id_rega_addr_i,
    input  logic              id_regb_read_i,
    input  logic [REG_AW-1:0] id_regb_addr_i,
    input  logic              id_regc_write_i,
    input  logic [REG_AW-1:0] id_regc_addr_i,
    output logic              load_use_o,
    output logic              mem_access_o
);

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (advance_i) begin
            mem_d = ex_q;
            if (bubble_i || !id_valid_i)
                ex_d = SLOT_EMPTY;
            else
                ex_d = decode_slot(id_op_i, id_regc_write_i, id_regc_addr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    // r0 is hard-wired zero, so a load into it never creates a dependency.
    // MEM-slot dependencies are covered by forwarding and never stall.
    always_comb begin
        load_use_o = 1'b0;
        if (ex_q.valid && ex_q.is_load && ex_q.wr && (ex_q.dest != '0)) begin
            load_use_o = (id_rega_read_i && (id_rega_addr_i == ex_q.dest)) ||
                         (id_regb_read_i && (id_regb_addr_i == ex_q.dest));
        end
    end

    assign mem_access_o = mem_q.valid && (mem_q.is_load || mem_q.is_store);

    // Destination of the MEM slot is only needed by the forwarding unit
    logic unused_mem_bits;
    assign unused_mem_bits = ^{mem_q.wr, mem_q.dest};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller beside the ID stage. Generates stall,
// bubble, flush and freeze controls from load-use hazards, taken jumps and
// multi-cycle data-memory accesses (with timeout into a sticky error state).
// Parameters:
//   MEM_WAIT_MAX  wait cycles tolerated for dmem_ack (1..255)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           pipe_hazard_ctrl_if.slave (ID fields, dmem_ack in;
//                 stall_if, stall_id, bubble_ex, flush_id, freeze,
//                 dmem_req, mem_timeout, stall_cycles out)
// Build option:
//   PIPE_HAZARD_CTRL_PERF_EN  enables the saturating stall_cycles counter;
//                             otherwise stall_cycles is tied to 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    // Count value at which the next unacknowledged wait cycle times out
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q;
    logic [7:0] wait_cnt_q;
    logic       mem_timeout_q;

    logic load_use;
    logic mem_access;
    logic dmem_req;
    logic freeze;
    logic stall;
    logic bubble;
    logic flush;

    hazard_scoreboard u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .advance_i       (!freeze),
        .bubble_i        (bubble),
        .id_valid_i      (bus.id_valid),
        .id_op_i         (bus.id_op),
        .id_rega_read_i  (bus.id_rega_read),
        .id_rega_addr_i  (bus.id_rega_addr),
        .id_regb_read_i  (bus.id_regb_read),
        .id_regb_addr_i  (bus.id_regb_addr),
        .id_regc_write_i (bus.id_regc_write),
        .id_regc_addr_i  (bus.id_regc_addr),
        .load_use_o      (load_use),
        .mem_access_o    (mem_access)
    );

    // Output priority: freeze beats the load-use stall, which beats the
    // jump flush. Everything is forced low while reset is sampled so a
    // pending access is dropped immediately.
    always_comb begin
        dmem_req = 1'b0;
        freeze   = 1'b0;
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        if (!rst) begin
            dmem_req = mem_access && (state_q != ST_ERROR);
            freeze   = (state_q == ST_ERROR) || (dmem_req && !bus.dmem_ack);
            if (freeze) begin
                stall = 1'b1;
            end else if (load_use) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else begin
                flush = bus.id_jce && bus.id_valid;
            end
        end
    end

    // Memory-wait FSM; an acknowledge in the last allowed wait cycle still
    // completes the access rather than timing out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    wait_cnt_q <= '0;
                    if (mem_access && !bus.dmem_ack)
                        state_q <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ack) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_q       <= ST_ERROR;
                            mem_timeout_q <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.stall_if    = stall;
    assign bus.stall_id    = stall;
    assign bus.bubble_ex   = bubble;
    assign bus.flush_id    = flush;
    assign bus.freeze      = freeze;
    assign bus.dmem_req    = dmem_req;
    assign bus.mem_timeout = mem_timeout_q && !rst;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_q <= '0;
        else if (stall && (stall_cycles_q != 32'hffff_ffff))
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign bus.stall_cycles = rst ? 32'd0 : stall_cycles_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (MEM_WAIT_MAX = 4). Each cycle the
// stimulus and the hand-derived expected controls are driven/pushed onto a
// queue; on the falling edge the entry is popped and compared with the DUT.
// The stall_cycles expectation is accumulated from the expected stall_if
// values when PIPE_HAZARD_CTRL_PERF_EN is defined, and is 0 otherwise.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int WAIT_MAX = 4;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_J   = 6'h02;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       valid;
        logic [5:0] op;
        logic       raRd;
        logic [4:0] ra;
        logic       rbRd;
        logic [4:0] rb;
        logic       wr;
        logic [4:0] rc;
        logic       jce;
    } stim_t;

    typedef struct packed {
        logic        stallIf;
        logic        stallId;
        logic        bubbleEx;
        logic        flushId;
        logic        freeze;
        logic        dmemReq;
        logic        memTimeout;
        logic [31:0] stallCycles;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] perfModel = 32'd0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic stim_t ins(input logic [5:0] op, input logic raRd,
                                  input logic [4:0] ra, input logic rbRd,
                                  input logic [4:0] rb, input logic wr,
                                  input logic [4:0] rc, input logic jce);
        stim_t s;
        s.valid = 1'b1; s.op = op; s.raRd = raRd; s.ra = ra;
        s.rbRd = rbRd; s.rb = rb; s.wr = wr; s.rc = rc; s.jce = jce;
        return s;
    endfunction

    function automatic exp_t ex(input logic sif, input logic sid, input logic bub,
                                input logic fl, input logic frz, input logic req,
                                input logic tmo);
        exp_t e;
        e.stallIf = sif; e.stallId = sid; e.bubbleEx = bub; e.flushId = fl;
        e.freeze = frz; e.dmemReq = req; e.memTimeout = tmo; e.stallCycles = 32'd0;
        return e;
    endfunction

    // Drive one cycle of inputs shortly after the rising edge and queue the
    // expected outputs for that cycle
    task automatic applyStimulus(input stim_t s, input logic ack,
                                 input logic rstIn, input exp_t e);
        exp_t full;
        @(posedge clk);
        #1;
        rst               = rstIn;
        bus.id_valid      = s.valid;
        bus.id_op         = s.op;
        bus.id_rega_read  = s.raRd;
        bus.id_rega_addr  = s.ra;
        bus.id_regb_read  = s.rbRd;
        bus.id_regb_addr  = s.rb;
        bus.id_regc_write = s.wr;
        bus.id_regc_addr  = s.rc;
        bus.id_jce        = s.jce;
        bus.dmem_ack      = ack;
        full = e;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        full.stallCycles = rstIn ? 32'd0 : perfModel;
        if (rstIn)
            perfModel = 32'd0;
        else if (e.stallIf && (perfModel != 32'hffff_ffff))
            perfModel = perfModel + 32'd1;
`else
        full.stallCycles = 32'd0;
`endif
        expQ.push_back(full);
    endtask

    // On the falling edge, pop the expectation and compare every output
    task automatic sampleOutputs(input string step);
        exp_t e;
        @(negedge clk);
        checkOutput({step, ".queue"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput({step, ".stall_if"},     32'(bus.stall_if),    32'(e.stallIf));
            checkOutput({step, ".stall_id"},     32'(bus.stall_id),    32'(e.stallId));
            checkOutput({step, ".bubble_ex"},    32'(bus.bubble_ex),   32'(e.bubbleEx));
            checkOutput({step, ".flush_id"},     32'(bus.flush_id),    32'(e.flushId));
            checkOutput({step, ".freeze"},       32'(bus.freeze),      32'(e.freeze));
            checkOutput({step, ".dmem_req"},     32'(bus.dmem_req),    32'(e.dmemReq));
            checkOutput({step, ".mem_timeout"},  32'(bus.mem_timeout), 32'(e.memTimeout));
            checkOutput({step, ".stall_cycles"}, bus.stall_cycles,     e.stallCycles);
        end
    endtask

    task automatic runCycle(input string step, input stim_t s, input logic ack,
                            input logic rstIn, input exp_t e);
        applyStimulus(s, ack, rstIn, e);
        sampleOutputs(step);
    endtask

    // Bound the whole run in case the sequencing above ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: load-use, r0 exemption, jump flush, memory waits,
    // timeout into ERROR and reset in the middle of a wait
    initial begin
        stim_t idle, lw3, add435, lw0, addr0, lw7, nord7, lw9, rb9;
        stim_t jmp, jmpInv, lw6, jr6, sw, lw8;
        exp_t  e0, eLu, eReq, eFrz, eFl, eLuReq, eFlReq, eErr;

        idle   = '0;
        idle.op = op_nop;
        lw3    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd3,  1'b0);
        add435 = ins(OP_ADD, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4,  1'b0);
        lw0    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd0,  1'b0);
        addr0  = ins(OP_ADD, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2,  1'b0);
        lw7    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd7,  1'b0);
        nord7  = ins(OP_ADD, 1'b0, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0,  1'b0);
        lw9    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd9,  1'b0);
        rb9    = ins(OP_ADD, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b0);
        jmp    = ins(OP_J,   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1);
        jmpInv = jmp;
        jmpInv.valid = 1'b0;
        lw6    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd6,  1'b0);
        jr6    = ins(op_jr,  1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1);
        sw     = ins(op_sw,  1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0,  1'b0);
        lw8    = ins(op_lw,  1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd8,  1'b0);

        e0     = ex(0, 0, 0, 0, 0, 0, 0);
        eLu    = ex(1, 1, 1, 0, 0, 0, 0);
        eReq   = ex(0, 0, 0, 0, 0, 1, 0);
        eFrz   = ex(1, 1, 0, 0, 1, 1, 0);
        eFl    = ex(0, 0, 0, 1, 0, 0, 0);
        eLuReq = ex(1, 1, 1, 0, 0, 1, 0);
        eFlReq = ex(0, 0, 0, 1, 0, 1, 0);
        eErr   = ex(1, 1, 0, 0, 1, 0, 1);

        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_op = op_nop; bus.id_rega_read = 1'b0;
        bus.id_rega_addr = '0; bus.id_regb_read = 1'b0; bus.id_regb_addr = '0;
        bus.id_regc_write = 1'b0; bus.id_regc_addr = '0; bus.id_jce = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] starting sequence");

        runCycle("reset", idle, 1'b0, 1'b1, e0);

        // Load-use through source a and b
        runCycle("lu_lw",    lw3,    1'b0, 1'b0, e0);
        runCycle("lu_stall", add435, 1'b0, 1'b0, eLu);
        runCycle("lu_after", add435, 1'b1, 1'b0, eReq);
        runCycle("lu_idle1", idle,   1'b0, 1'b0, e0);
        runCycle("lu_idle2", idle,   1'b0, 1'b0, e0);

        // Load into r0 never stalls; unread source never stalls
        runCycle("r0_lw",    lw0,    1'b0, 1'b0, e0);
        runCycle("r0_use",   addr0,  1'b0, 1'b0, e0);
        runCycle("r0_mem",   idle,   1'b1, 1'b0, eReq);
        runCycle("nord_lw",  lw7,    1'b0, 1'b0, e0);
        runCycle("nord_use", nord7,  1'b0, 1'b0, e0);
        runCycle("nord_mem", idle,   1'b1, 1'b0, eReq);
        runCycle("rb_lw",    lw9,    1'b0, 1'b0, e0);
        runCycle("rb_stall", rb9,    1'b0, 1'b0, eLu);
        runCycle("rb_after", rb9,    1'b1, 1'b0, eReq);
        runCycle("rb_idle1", idle,   1'b0, 1'b0, e0);
        runCycle("rb_idle2", idle,   1'b0, 1'b0, e0);

        // Jump flush, invalid jump ignored, jr behind a load stalls first
        runCycle("j_flush",  jmp,    1'b0, 1'b0, eFl);
        runCycle("j_inv",    jmpInv, 1'b0, 1'b0, e0);
        runCycle("j_idle",   idle,   1'b0, 1'b0, e0);
        runCycle("jr_lw",    lw6,    1'b0, 1'b0, e0);
        runCycle("jr_stall", jr6,    1'b0, 1'b0, eLu);
        runCycle("jr_flush", jr6,    1'b1, 1'b0, eFlReq);
        runCycle("jr_idle1", idle,   1'b0, 1'b0, e0);
        runCycle("jr_idle2", idle,   1'b0, 1'b0, e0);

        // Store waits 3 cycles for ack; jump in ID is held, flushed on ack
        runCycle("sw_id",    sw,     1'b0, 1'b0, e0);
        runCycle("sw_ex",    idle,   1'b0, 1'b0, e0);
        runCycle("sw_wait1", jmp,    1'b0, 1'b0, eFrz);
        runCycle("sw_wait2", jmp,    1'b0, 1'b0, eFrz);
        runCycle("sw_wait3", jmp,    1'b0, 1'b0, eFrz);
        runCycle("sw_ack",   jmp,    1'b1, 1'b0, eFlReq);
        runCycle("sw_idle",  idle,   1'b0, 1'b0, e0);
        runCycle("perf_rst", idle,   1'b0, 1'b1, e0);

        // Load-use hidden behind a 4-cycle memory freeze, released with ack
        runCycle("mix_sw",   sw,     1'b0, 1'b0, e0);
        runCycle("mix_lw",   lw3,    1'b0, 1'b0, e0);
        runCycle("mix_frz1", add435, 1'b0, 1'b0, eFrz);
        runCycle("mix_frz2", add435, 1'b0, 1'b0, eFrz);
        runCycle("mix_frz3", add435, 1'b0, 1'b0, eFrz);
        runCycle("mix_frz4", add435, 1'b0, 1'b0, eFrz);
        runCycle("mix_ack",  add435, 1'b1, 1'b0, eLuReq);
        runCycle("mix_lwm",  add435, 1'b1, 1'b0, eReq);
        runCycle("mix_idl1", idle,   1'b0, 1'b0, e0);
        runCycle("mix_idl2", idle,   1'b0, 1'b0, e0);

        // Timeout: 4 MEM_WAIT cycles without ack, ERROR holds until reset
        runCycle("to_lw",    lw8,    1'b0, 1'b0, e0);
        runCycle("to_ex",    idle,   1'b0, 1'b0, e0);
        runCycle("to_run",   idle,   1'b0, 1'b0, eFrz);
        runCycle("to_w1",    idle,   1'b0, 1'b0, eFrz);
        runCycle("to_w2",    idle,   1'b0, 1'b0, eFrz);
        runCycle("to_w3",    idle,   1'b0, 1'b0, eFrz);
        runCycle("to_w4",    idle,   1'b0, 1'b0, eFrz);
        runCycle("to_err",   idle,   1'b0, 1'b0, eErr);
        runCycle("to_errak", idle,   1'b1, 1'b0, eErr);
        runCycle("to_rst",   idle,   1'b0, 1'b1, e0);
        runCycle("to_after", idle,   1'b0, 1'b0, e0);

        // Reset in the middle of a wait drops the access immediately
        runCycle("mr_sw",    sw,     1'b0, 1'b0, e0);
        runCycle("mr_ex",    idle,   1'b0, 1'b0, e0);
        runCycle("mr_wait",  idle,   1'b0, 1'b0, eFrz);
        runCycle("mr_rst",   idle,   1'b0, 1'b1, e0);
        runCycle("mr_after", idle,   1'b0, 1'b0, e0);
        runCycle("mr_idle",  idle,   1'b0, 1'b0, e0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
